// File: rtl/uart_tx_flow.sv
// uart_tx_flow: 8N1 UART transmitter with byte FIFO and synchronised CTS flow control.
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   wr_en    push wr_data into the FIFO
//   wr_data  byte to transmit
//   full     FIFO holds FIFO_DEPTH entries
//   empty    FIFO holds no entries
//   overflow one-cycle pulse after a write was dropped on a full FIFO
//   cts_n_i  active-low clear-to-send, asynchronous to clk
//   tx_o     registered serial output, idle high
//   busy     a frame is in progress
module uart_tx_flow #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    input  logic       cts_n_i,
    output logic       tx_o,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          cts_meta, cts_sync;
    logic          cts_ok, bit_end, push, pop;

    assign cts_ok   = ~cts_sync;
    assign full     = count == (AW+1)'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign busy     = state != IDLE;
    assign bit_end  = cnt == CW'(CLKS_PER_BIT - 1);
    assign push     = wr_en & ~full;
    // CTS is only consulted when a new frame may begin: from IDLE or at the last cycle of STOP
    assign pop      = ~empty & cts_ok & (state == IDLE | (state == STOP & bit_end));

    always_ff @(posedge clk or posedge reset)
        if (reset) {cts_sync, cts_meta} <= 2'b11;
        else       {cts_sync, cts_meta} <= {cts_meta, cts_n_i};

    always_ff @(posedge clk)
        if (push) mem[wptr] <= wr_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wptr     <= wptr + AW'(push);
            rptr     <= rptr + AW'(pop);
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow <= wr_en & full;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            tx_o  <= 1'b1;
        end else begin
            case (state)
                IDLE:
                    if (pop) begin
                        shift <= mem[rptr];
                        cnt   <= '0;
                        tx_o  <= 1'b0;
                        state <= START;
                    end
                START:
                    if (bit_end) begin
                        cnt   <= '0;
                        idx   <= '0;
                        tx_o  <= shift[0];
                        state <= DATA;
                    end else cnt <= cnt + CW'(1);
                DATA:
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= shift >> 1;
                        if (idx == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end else begin
                            idx  <= idx + 3'd1;
                            tx_o <= shift[1];
                        end
                    end else cnt <= cnt + CW'(1);
                default:
                    if (bit_end) begin
                        cnt <= '0;
                        // chain straight into the next start bit when more data is ready
                        if (pop) begin
                            shift <= mem[rptr];
                            tx_o  <= 1'b0;
                            state <= START;
                        end else state <= IDLE;
                    end else cnt <= cnt + CW'(1);
            endcase
        end
endmodule

// File: tb/tb_uart_tx_flow.sv
// tb_uart_tx_flow: frame-timing reference model, line decoder and directed plus random stimulus for uart_tx_flow.
module tb_uart_tx_flow;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FL    = 10 * CPB;

    logic       clk = 1'b0, reset = 1'b1, wr_en = 1'b0, cts_n_i = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, tx_o, busy;
    int         total = 0, bad = 0;

    uart_tx_flow #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .overflow(overflow),
        .cts_n_i(cts_n_i), .tx_o(tx_o), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: a queue of bytes plus the elapsed time of the current frame.
    byte unsigned m_q[$], m_sent[$];
    logic [7:0]   m_cur = 8'h00;
    int           m_t = 0;
    bit           m_act = 1'b0, m_ov = 1'b0, m_ok, m_fin, m_pop, m_acc;
    logic [1:0]   m_sync = 2'b11;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_act  = 1'b0;
            m_t    = 0;
            m_ov   = 1'b0;
            m_sync = 2'b11;
        end else begin
            m_ok  = !m_sync[1];
            m_fin = m_act && m_t == FL - 1;
            m_pop = (!m_act || m_fin) && m_q.size() > 0 && m_ok;
            m_acc = wr_en && m_q.size() < DEPTH;
            m_ov  = wr_en && m_q.size() == DEPTH;
            if (m_act) begin
                if (m_fin) m_act = 1'b0;
                else m_t++;
            end
            if (m_pop) begin
                m_cur = m_q.pop_front();
                m_sent.push_back(m_cur);
                m_act = 1'b1;
                m_t   = 0;
            end
            if (m_acc) m_q.push_back(wr_data);
            m_sync = {m_sync[0], cts_n_i};
        end
    end

    function automatic logic exp_tx();
        int k;
        if (!m_act) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("tx", tx_o, exp_tx());
            chk("busy", busy, m_act);
            chk("full", full, m_q.size() == DEPTH);
            chk("empty", empty, m_q.size() == 0);
            chk("overflow", overflow, m_ov);
        end
    end

    // Line decoder: samples mid-bit, drops frames cut by reset.
    byte unsigned rx_q[$];
    logic [7:0]   rx_b;
    bit           rx_ab;

    task automatic rx_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (reset) rx_ab = 1'b1;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!reset && tx_o === 1'b0) begin
            rx_ab = 1'b0;
            rx_wait(CPB / 2);
            for (int i = 0; i < 8; i++) begin
                rx_wait(CPB);
                rx_b[i] = tx_o;
            end
            rx_wait(CPB);
            if (!rx_ab) begin
                chk("stop_bit", tx_o, 1'b1);
                rx_q.push_back(rx_b);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cyc(1);
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_q.size() != 0 || m_act) && n < 3000) begin
            cyc(1);
            n++;
        end
        chk("drain_timeout", n < 3000, 1'b1);
        cyc(CPB);
    endtask

    task automatic rx_is(input string nm, input int i, input logic [7:0] e);
        chk(nm, i < rx_q.size() ? 32'(rx_q[i]) : 32'hffff, 32'(e));
    endtask

    task automatic check_rx(input string nm);
        chk({nm, "_count"}, rx_q.size(), m_sent.size());
        for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++) chk(nm, rx_q[i], m_sent[i]);
        rx_q.delete();
        m_sent.delete();
    endtask

    initial begin
        logic [9:0] fr;
        int n, nb, sent;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx", tx_o, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_ovf", overflow, 1'b0);
        reset = 1'b0;

        // single byte, literal waveform
        cts_n_i = 1'b0;
        cyc(3);
        fr = 10'b1_10100101_0;
        wr(8'hA5);
        for (int i = 0; i < FL; i++) begin
            @(posedge clk);
            #1;
            chk("a5_wave", tx_o, fr[i/CPB]);
            chk("a5_busy", busy, 1'b1);
            if (i == 0) chk("a5_empty", empty, 1'b1);
        end
        @(posedge clk);
        #1;
        chk("a5_end_busy", busy, 1'b0);
        chk("a5_end_tx", tx_o, 1'b1);
        #1;
        cyc(CPB);
        rx_is("a5_rx", 0, 8'hA5);
        check_rx("a5");

        // back-to-back frames with no idle gap
        nb = 0;
        wr_en = 1'b1;
        wr_data = 8'h55;
        cyc(1);
        nb += int'(busy);
        wr_data = 8'h0F;
        cyc(1);
        nb += int'(busy);
        wr_data = 8'hFF;
        cyc(1);
        nb += int'(busy);
        wr_en = 1'b0;
        repeat (130) begin
            cyc(1);
            nb += int'(busy);
        end
        chk("b2b_busy_cycles", nb, 3 * FL);
        rx_is("b2b_rx0", 0, 8'h55);
        rx_is("b2b_rx1", 1, 8'h0F);
        rx_is("b2b_rx2", 2, 8'hFF);
        check_rx("b2b");

        // flow control hold, release latency, mid-frame deassert
        cts_n_i = 1'b1;
        cyc(3);
        wr(8'h3C);
        repeat (100) begin
            cyc(1);
            chk("cts_hold_tx", tx_o, 1'b1);
            chk("cts_hold_busy", busy, 1'b0);
        end
        cts_n_i = 1'b0;
        n = 0;
        while (tx_o !== 1'b0 && n < 10) begin
            cyc(1);
            n++;
        end
        chk("cts_latency", n, 3);
        cyc(15);
        cts_n_i = 1'b1;
        drain();
        rx_is("cts_rx", 0, 8'h3C);
        check_rx("cts");

        // full and overflow with CTS held off
        wr_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_data = 8'(8'h11 * (k + 1));
            cyc(1);
            chk("fill_full", full, k >= 3);
            chk("fill_ovf", overflow, k == 4);
        end
        wr_en = 1'b0;
        cyc(1);
        chk("ovf_clear", overflow, 1'b0);
        chk("still_full", full, 1'b1);
        cts_n_i = 1'b0;
        drain();
        chk("ovf_rx_count", rx_q.size(), 4);
        rx_is("ovf_rx0", 0, 8'h11);
        rx_is("ovf_rx1", 1, 8'h22);
        rx_is("ovf_rx2", 2, 8'h33);
        rx_is("ovf_rx3", 3, 8'h44);
        check_rx("ovf");

        // pointer wrap: stream without overfilling
        sent = 0;
        n = 0;
        while (sent < 10 && n < 2000) begin
            if (!full) begin
                wr_en = 1'b1;
                wr_data = 8'(sent);
                sent++;
            end else wr_en = 1'b0;
            cyc(1);
            n++;
        end
        wr_en = 1'b0;
        chk("wrap_sent", sent, 10);
        drain();
        for (int i = 0; i < 10; i++) rx_is("wrap_rx", i, 8'(i));
        check_rx("wrap");

        // reset during data bit 3 with two bytes queued
        wr_en = 1'b1;
        wr_data = 8'hC3;
        cyc(1);
        wr_data = 8'h81;
        cyc(1);
        wr_data = 8'h7E;
        cyc(1);
        wr_en = 1'b0;
        cyc(16);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", tx_o, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_full", full, 1'b0);
        cyc(1);
        reset = 1'b0;
        rx_q.delete();
        m_sent.delete();
        repeat (60) begin
            cyc(1);
            chk("post_rst_tx", tx_o, 1'b1);
            chk("post_rst_busy", busy, 1'b0);
        end
        chk("post_rst_rx", rx_q.size(), 0);
        wr(8'h5A);
        drain();
        rx_is("post_rst_frame", 0, 8'h5A);
        check_rx("post_rst");

        // randomized traffic with CTS toggling
        repeat (3000) begin
            wr_en = $urandom_range(0, 3) == 0;
            wr_data = 8'($urandom);
            if ($urandom_range(0, 59) == 0) cts_n_i = ~cts_n_i;
            cyc(1);
        end
        wr_en = 1'b0;
        cts_n_i = 1'b0;
        drain();
        check_rx("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
